// File: rtl/axis_pkg.sv
// Shared types for the 1-to-2 AXI-Stream packet router.
package axis_pkg;

    typedef enum logic {DEST_A = 1'b0, DEST_B = 1'b1} dest_e;

    typedef enum logic {ST_IDLE = 1'b0, ST_ROUTE = 1'b1} route_st_e;

endpackage

// File: rtl/axis_reg_slice.sv
// One-entry AXI-Stream register slice: a load overwrites the held beat, and the beat
// drains on out_valid & out_ready.
module axis_reg_slice #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              last_q, last_d;

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = in_data;
            last_d  = in_last;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_last  = last_q;

endmodule

// File: rtl/axis_router.sv
// 1-to-2 AXI-Stream packet router: tdest on a packet's first beat picks m0a or m0b,
// and that choice holds until tlast. Each output has a one-entry register slice.
module axis_router
    import axis_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              axis_aclk,
    input  logic              axis_areset,
    input  logic [DATA_W-1:0] s0k_axis_tdata,
    input  logic              s0k_axis_tvalid,
    output logic              s0k_axis_tready,
    input  logic              s0k_axis_tlast,
    input  logic              s0k_axis_tdest,
    output logic [DATA_W-1:0] m0a_axis_tdata,
    output logic              m0a_axis_tvalid,
    input  logic              m0a_axis_tready,
    output logic              m0a_axis_tlast,
    output logic [DATA_W-1:0] m0b_axis_tdata,
    output logic              m0b_axis_tvalid,
    input  logic              m0b_axis_tready,
    output logic              m0b_axis_tlast,
    output logic [CNT_W-1:0]  m0a_pkt_count,
    output logic [CNT_W-1:0]  m0b_pkt_count
);

    route_st_e        state_q, state_d;
    dest_e            sel_q, sel_d, sel;
    logic             s_hs, load_a, load_b;
    logic [CNT_W-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;

    assign s_hs = s0k_axis_tvalid && s0k_axis_tready;

    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            state_q <= ST_IDLE;
            sel_q   <= DEST_A;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        case (state_q)
            ST_IDLE: begin
                if (s_hs && !s0k_axis_tlast) begin
                    state_d = ST_ROUTE;
                    sel_d   = dest_e'(s0k_axis_tdest);
                end
            end
            ST_ROUTE: begin
                if (s_hs && s0k_axis_tlast) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Idle follows tdest live so a packet's first beat already goes to the right port.
    always_comb begin
        sel    = (state_q == ST_IDLE) ? dest_e'(s0k_axis_tdest) : sel_q;
        load_a = s_hs && (sel == DEST_A);
        load_b = s_hs && (sel == DEST_B);
        if (sel == DEST_A) s0k_axis_tready = !m0a_axis_tvalid || m0a_axis_tready;
        else               s0k_axis_tready = !m0b_axis_tvalid || m0b_axis_tready;
    end

    axis_reg_slice #(.DATA_W(DATA_W)) u_slice_a (
        .clk       (axis_aclk),
        .rst       (axis_areset),
        .load      (load_a),
        .in_data   (s0k_axis_tdata),
        .in_last   (s0k_axis_tlast),
        .out_valid (m0a_axis_tvalid),
        .out_data  (m0a_axis_tdata),
        .out_last  (m0a_axis_tlast),
        .out_ready (m0a_axis_tready)
    );

    axis_reg_slice #(.DATA_W(DATA_W)) u_slice_b (
        .clk       (axis_aclk),
        .rst       (axis_areset),
        .load      (load_b),
        .in_data   (s0k_axis_tdata),
        .in_last   (s0k_axis_tlast),
        .out_valid (m0b_axis_tvalid),
        .out_data  (m0b_axis_tdata),
        .out_last  (m0b_axis_tlast),
        .out_ready (m0b_axis_tready)
    );

    always_comb begin
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        if (m0a_axis_tvalid && m0a_axis_tready && m0a_axis_tlast) cnt_a_d = cnt_a_q + CNT_W'(1);
        if (m0b_axis_tvalid && m0b_axis_tready && m0b_axis_tlast) cnt_b_d = cnt_b_q + CNT_W'(1);
    end

    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end

    assign m0a_pkt_count = cnt_a_q;
    assign m0b_pkt_count = cnt_b_q;

endmodule
